// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between the CPU bus and the front panel.
// One access in flight; a watchdog forces completion if the RAM never acknowledges.
module mem_arbiter #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 15,
  parameter int CTR_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             cpu_we,
  input  logic             cpu_load,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_ready,
  input  logic [WIDTH-1:0] pnl_addr,
  input  logic [WIDTH-1:0] pnl_wdata,
  input  logic             pnl_we,
  input  logic             pnl_load,
  output logic [WIDTH-1:0] pnl_rdata,
  output logic             pnl_ready,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_we,
  output logic             ram_en,
  input  logic [WIDTH-1:0] ram_rdata,
  input  logic             ram_ready,
  output logic             busy,
  output logic             grant_pnl,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             r_state, w_next;
  logic               r_gnt_pnl, w_gnt_pnl;
  logic               w_take, w_ack, w_expire, w_fin;
  logic [CTR_W-1:0]   r_ctr;
  logic [WIDTH-1:0]   r_ram_addr, r_ram_wdata, w_rdata;
  logic               r_ram_we, r_ram_en;
  logic [WIDTH-1:0]   r_cpu_rdata, r_pnl_rdata;
  logic               r_cpu_ready, r_pnl_ready, r_tmo;

  // ram_ready only counts in WAIT; it beats a simultaneous watchdog expiry
  assign w_ack    = (r_state == WAIT) && ram_ready;
  assign w_expire = (r_state == WAIT) && !ram_ready && (r_ctr == CTR_W'(TIMEOUT));
  assign w_fin    = w_ack | w_expire;
  assign w_rdata  = w_ack ? ram_rdata : '0;

  always_comb begin
    w_next    = r_state;
    w_gnt_pnl = r_gnt_pnl;
    w_take    = 1'b0;
    case (r_state)
      IDLE: if (cpu_load || pnl_load) begin
        w_take    = 1'b1;
        w_gnt_pnl = (cpu_load && pnl_load) ? ~r_gnt_pnl : pnl_load;
        w_next    = ISSUE;
      end
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_fin) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt_pnl   <= 1'b1;
      r_ctr       <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_ram_en    <= 1'b0;
      r_cpu_rdata <= '0;
      r_pnl_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_pnl_ready <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ram_en    <= w_take;
      r_cpu_ready <= w_fin & ~r_gnt_pnl;
      r_pnl_ready <= w_fin & r_gnt_pnl;
      if (w_take) begin
        r_gnt_pnl   <= w_gnt_pnl;
        r_ram_addr  <= w_gnt_pnl ? pnl_addr  : cpu_addr;
        r_ram_wdata <= w_gnt_pnl ? pnl_wdata : cpu_wdata;
        r_ram_we    <= w_gnt_pnl ? pnl_we    : cpu_we;
      end
      if (r_state == ISSUE)     r_ctr <= '0;
      else if (r_state == WAIT) r_ctr <= r_ctr + 1'b1;
      if (w_fin) begin
        if (r_gnt_pnl) r_pnl_rdata <= w_rdata;
        else           r_cpu_rdata <= w_rdata;
      end
      if (w_expire) r_tmo <= 1'b1;
    end
  end

  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign ram_we      = r_ram_we;
  assign ram_en      = r_ram_en;
  assign cpu_rdata   = r_cpu_rdata;
  assign pnl_rdata   = r_pnl_rdata;
  assign cpu_ready   = r_cpu_ready;
  assign pnl_ready   = r_pnl_ready;
  assign busy        = (r_state != IDLE);
  assign grant_pnl   = r_gnt_pnl;
  assign timeout_err = r_tmo;

endmodule
